// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage and its neighbours: execute redirects, the
// program_memory req/ack port and the decode-facing instruction stream.
interface fetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic            i_dec_ready;
    logic            i_inst_ack;
    logic [XLEN-1:0] i_inst_received;
    logic            o_inst_req;
    logic [XLEN-1:0] o_inst_addr;
    logic            o_valid;
    logic [XLEN-1:0] o_inst;
    logic [XLEN-1:0] o_pc;
    logic [1:0]      dbg_state;

    // Memory port: a transfer completes on a rising edge with o_inst_req=1 and
    // i_inst_ack=1; o_inst_req/o_inst_addr stay constant until that edge.
    // Decode port: the head entry is consumed on a rising edge with
    // o_valid=1 and i_dec_ready=1.
    modport master (
        input  i_redirect, i_redirect_pc, i_dec_ready, i_inst_ack, i_inst_received,
        output o_inst_req, o_inst_addr, o_valid, o_inst, o_pc, dbg_state
    );

    modport slave (
        output i_redirect, i_redirect_pc, i_dec_ready, i_inst_ack, i_inst_received,
        input  o_inst_req, o_inst_addr, o_valid, o_inst, o_pc, dbg_state
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, program_memory req/ack,
// a small in-order instruction buffer and redirect/flush handling.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input logic          i_clk,
    input logic          i_rst_n,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state;
    logic              inst_req;
    logic [XLEN-1:0]   inst_addr;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   drop_target;
    logic [XLEN-1:0]   head_inst;
    logic [XLEN-1:0]   head_pc;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [XLEN-1:0]   mem_inst [FIFO_DEPTH];
    logic [XLEN-1:0]   mem_pc   [FIFO_DEPTH];

    logic              valid;
    logic              pop;
    logic              ack;
    logic              push;
    logic [XLEN-1:0]   redirect_pc;
    logic [XLEN-1:0]   next_addr;
    logic [CNT_W-1:0]  count_rem;
    logic [CNT_W-1:0]  count_nxt;
    logic [PTR_W-1:0]  rd_nxt;
    logic              room_now;
    logic              room_after;

    assign valid       = (count != '0);
    assign pop         = valid && bus.i_dec_ready;
    assign ack         = inst_req && bus.i_inst_ack;
    assign push        = (state == REQ) && ack && !bus.i_redirect;
    assign redirect_pc = bus.i_redirect_pc & ~XLEN'(3);
    assign next_addr   = inst_addr + XLEN'(4);
    assign count_rem   = count - CNT_W'(pop);
    assign count_nxt   = count_rem + CNT_W'(push);
    assign rd_nxt      = rd_ptr + PTR_W'(pop);
    // Room is judged after this edge's pop (and push), so a full buffer being
    // drained can refill back-to-back without ever overflowing.
    assign room_now    = count_rem < CNT_W'(FIFO_DEPTH);
    assign room_after  = count_nxt < CNT_W'(FIFO_DEPTH);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= bus.i_inst_received;
            mem_pc[wr_ptr]   <= inst_addr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            inst_req    <= 1'b0;
            inst_addr   <= RESET_PC;
            fetch_pc    <= RESET_PC;
            drop_target <= RESET_PC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            head_inst   <= NOP;
            head_pc     <= RESET_PC;
        end else begin
            if (bus.i_redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count  <= count_nxt;
                rd_ptr <= rd_nxt;
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                // Head registers keep the last head value whenever the buffer empties.
                if (count_nxt != '0) begin
                    if (count_rem == '0) begin
                        head_inst <= bus.i_inst_received;
                        head_pc   <= inst_addr;
                    end else begin
                        head_inst <= mem_inst[rd_nxt];
                        head_pc   <= mem_pc[rd_nxt];
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (bus.i_redirect) begin
                        state     <= REQ;
                        inst_req  <= 1'b1;
                        inst_addr <= redirect_pc;
                        fetch_pc  <= redirect_pc;
                    end else if (room_now) begin
                        state     <= REQ;
                        inst_req  <= 1'b1;
                        inst_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (ack) begin
                        if (bus.i_redirect) begin
                            inst_addr <= redirect_pc;
                            fetch_pc  <= redirect_pc;
                        end else begin
                            fetch_pc <= next_addr;
                            if (room_after) begin
                                inst_addr <= next_addr;
                            end else begin
                                inst_req <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end else if (bus.i_redirect) begin
                        drop_target <= redirect_pc;
                        state       <= DROP;
                    end
                end
                DROP: begin
                    // The discarded response retires the old request; the newest
                    // redirect target wins, even one arriving on this very edge.
                    if (ack) begin
                        state     <= REQ;
                        inst_addr <= bus.i_redirect ? redirect_pc : drop_target;
                        fetch_pc  <= bus.i_redirect ? redirect_pc : drop_target;
                    end else if (bus.i_redirect) begin
                        drop_target <= redirect_pc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    inst_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_inst_req  = inst_req;
    assign bus.o_inst_addr = inst_addr;
    assign bus.o_valid     = valid;
    assign bus.o_inst      = head_inst;
    assign bus.o_pc        = head_pc;
    assign bus.dbg_state   = state;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage between the cpu pipeline front end and program_memory. It generates sequential PCs and drives the program_memory req/ack handshake. Fetched words are buffered in a small FIFO and presented to decode as valid/ready instruction+PC pairs. Branch/jump redirects from execute flush the buffer and discard any in-flight response.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
i_clk  input  1  CPU clock, rising-edge
i_rst_n  input  1  reset, asynchronous, active-low
i_redirect  input  1  one-cycle pulse from execute: taken branch/jump/trap
i_redirect_pc  input  XLEN  new fetch PC, sampled when i_redirect=1
i_dec_ready  input  1  decode accepts head entry this cycle
i_inst_ack  input  1  program_memory acknowledge; i_inst_received valid this cycle
i_inst_received  input  XLEN  instruction word from program_memory
o_inst_req  output  1  instruction request to program_memory
o_inst_addr  output  XLEN  instruction address; stable while request outstanding
o_valid  output  1  FIFO head valid
o_inst  output  XLEN  FIFO head instruction
o_pc  output  XLEN  PC of FIFO head instruction

Behaviour:
- Reset (async, i_rst_n=0): o_inst_req=0, o_inst_addr=RESET_PC, o_valid=0, o_inst=32'h0000_0013 (NOP), o_pc=RESET_PC, FIFO empty, state IDLE, fetch PC=RESET_PC. Reset asserted mid-request abandons it immediately; no response from before reset is ever written to the FIFO.
- Handshake: a transfer completes on a rising edge where o_inst_req=1 and i_inst_ack=1. i_inst_ack with o_inst_req=0 is ignored. o_inst_addr and o_inst_req are registered and held constant until the completing edge. After completion the next request may be issued immediately in the following cycle (back-to-back).
- Issue rule: issue a request when (FIFO count + outstanding) < FIFO_DEPTH, or when count frees on the same edge via pop. No request is issued while the FIFO is full.
- States:
  IDLE: no outstanding request. -> REQ when issue rule is satisfied.
  REQ: request outstanding. On ack, write {i_inst_received, o_inst_addr} into the FIFO and set fetch PC += 4, then go to REQ (next address) or IDLE. On i_redirect without ack -> DROP.
  DROP: request outstanding whose response must be discarded. Address is still held. On ack, discard the response and immediately issue i_redirect_pc (latched) -> REQ.
- Redirect: flush all FIFO entries in the same cycle (o_valid=0 from the next edge), latch i_redirect_pc with bits [1:0] forced to 0. From IDLE, the request to the redirect PC is issued the next cycle. If i_redirect coincides with a completing ack in REQ, the response is discarded, the FIFO is not written, and the redirect PC is issued the next cycle. A redirect in DROP overwrites the latched target; the unit stays in DROP.
- Latency: ack at edge N -> o_valid=1 with that instruction after edge N (visible in cycle N+1). There is no combinational bypass from i_inst_received to o_inst.
- FIFO: pop occurs when o_valid && i_dec_ready. Simultaneous push and pop with the FIFO full is legal and leaves count unchanged. Pointers wrap modulo FIFO_DEPTH. Redirect takes priority over push and pop. o_inst/o_pc hold the last head value when empty.
- PC arithmetic: fetch PC += 4, modulo 2^XLEN (32'hFFFF_FFFC wraps to 0).

Test Plan:
- Reset then zero-wait memory (ack one cycle after each req), i_dec_ready=1 -> o_inst_addr sequence 0x0,0x4,0x8; o_valid first high the cycle after the first ack with o_pc=0x0; o_inst_req=0 and o_valid=0 throughout reset.
- i_dec_ready=0 for 10 cycles -> exactly 2 entries buffered (PCs 0x0,0x4); o_inst_req stays 0 after the second ack. Raise ready -> in-order pop 0x0,0x4, and fetch resumes at 0x8.
- Memory ack delayed 3 cycles -> o_inst_addr constant and o_inst_req held high for all 3 cycles.
- i_redirect with i_redirect_pc=0x103 while request to 0x8 is outstanding -> response for 0x8 discarded, FIFO flushed, next o_inst_addr=0x100, first valid o_pc=0x100.
- i_redirect in the same cycle as the ack for 0xC -> 0xC is never presented; next request is to the redirect PC.
- Assert i_rst_n=0 mid-request, then release -> o_inst_req drops asynchronously, FIFO empty, and the first request after release is to RESET_PC.
